pe_stream_driver: RTL

PE_STREAM_DRIVER -- requirements
Module: pe_stream_driver

---
 rtl/dsp_sys_arr_pkg.sv | 36 +++
 rtl/pe_operand_buf.sv | 47 ++++
 rtl/pe_stream_driver.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/dsp_sys_arr_pkg.sv
// rtl/dsp_sys_arr_pkg.sv - shared types and defaults for the PE stream driver
//
// Purpose : operand/error types, driver defaults, driver FSM state encoding
//           and a pointer-width helper used by pe_stream_driver and
//           pe_operand_buf.
// Contents: single_float, error, operand_pair, pe_drv_state,
//           PE_DRV_DEPTH, PE_DRV_TIMEOUT, ptr_w().

package dsp_sys_arr_pkg;

   localparam int PE_DRV_DEPTH   = 8;
   localparam int PE_DRV_TIMEOUT = 1024;

   typedef logic [31:0] single_float;
   typedef logic [3:0]  error;

   // One buffered entry: row operand in the upper half, column in the lower.
   typedef struct packed {
      single_float row;
      single_float col;
   } operand_pair;

   typedef enum logic [1:0] {
      LOAD   = 2'd0,
      STREAM = 2'd1,
      WAIT   = 2'd2,
      RESULT = 2'd3
   } pe_drv_state;

   // Counters must hold the value DEPTH itself (a full buffer), not just
   // the highest index, hence depth+1.
   function automatic int ptr_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/pe_operand_buf.sv
// rtl/pe_operand_buf.sv - DEPTH x 64-bit operand register file, 1W/2R
//
// Purpose : holds the row/column operand pairs of one dot-product vector.
//           The two read ports are combinational so each stream's data
//           follows its own read pointer and stays stable while the
//           pointer does.
// Ports   : i_clk              clock
//           i_we, i_waddr      write enable / index
//           i_wdata            operand pair to store
//           i_raddr_a/o_rdata_a  read port A (row stream)
//           i_raddr_b/o_rdata_b  read port B (column stream)

module pe_operand_buf
   import dsp_sys_arr_pkg::*;
#(
   parameter int DEPTH = PE_DRV_DEPTH,
   localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          i_clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  operand_pair   i_wdata,
   input  logic [AW-1:0] i_raddr_a,
   output operand_pair   o_rdata_a,
   input  logic [AW-1:0] i_raddr_b,
   output operand_pair   o_rdata_b
);

   operand_pair r_mem [DEPTH];

   // Contents are don't-care after reset, so the array carries no reset.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Only a non-power-of-two depth can present an address past the end.
   if ((2 ** AW) == DEPTH) begin : g_full_decode
      assign o_rdata_a = r_mem[i_raddr_a];
      assign o_rdata_b = r_mem[i_raddr_b];
   end else begin : g_guarded_decode
      assign o_rdata_a = (i_raddr_a < AW'(DEPTH)) ? r_mem[i_raddr_a] : '0;
      assign o_rdata_b = (i_raddr_b < AW'(DEPTH)) ? r_mem[i_raddr_b] : '0;
   end

endmodule

// File: rtl/pe_stream_driver.sv
// rtl/pe_stream_driver.sv - buffers operand pairs and streams them into a PE
//
// Purpose : LOAD collects up to DEPTH row/column operand pairs, STREAM feeds
//           them to the PE on two independently handshaked streams, WAIT
//           holds until the PE reports comp_done, RESULT presents the
//           captured accumulator until it is accepted.
// Config  : PE_STREAM_DRIVER_TIMEOUT_EN - when defined, WAIT gives up after
//           TIMEOUT cycles and returns an error result flagged on
//           res_timeout.
// Ports   : clk, rst                      clock, sync active-high reset
//           ld_*                          load stream (valid/ready/last)
//           row_in_*, col_in_*            operand streams to the PE
//           row_out_*, col_out_*          PE forwarded streams (drained)
//           comp_done, error_bit,
//           accum_sum, user               PE completion status
//           res_*                         result stream
//           busy                          high outside LOAD

module pe_stream_driver
   import dsp_sys_arr_pkg::*;
#(
   parameter int DEPTH   = PE_DRV_DEPTH,
   parameter int TIMEOUT = PE_DRV_TIMEOUT
) (
   input  logic        clk,
   input  logic        rst,
   // load side
   input  logic        ld_valid,
   output logic        ld_ready,
   input  single_float ld_row_dat,
   input  single_float ld_col_dat,
   input  logic        ld_last,
   // operand streams to the PE
   output single_float row_in_dat,
   output single_float col_in_dat,
   output logic        row_in_valid,
   output logic        col_in_valid,
   input  logic        row_in_ready,
   input  logic        col_in_ready,
   // forwarded streams from the PE
   input  single_float row_out_dat,
   input  single_float col_out_dat,
   input  logic        row_out_valid,
   input  logic        col_out_valid,
   output logic        row_out_ready,
   output logic        col_out_ready,
   // PE completion
   input  logic        comp_done,
   input  logic        error_bit,
   input  single_float accum_sum,
   input  error        user,
   // result stream
   output logic        res_valid,
   input  logic        res_ready,
   output single_float res_dat,
   output logic        res_err,
   output error        res_user,
`ifdef PE_STREAM_DRIVER_TIMEOUT_EN
   output logic        res_timeout,
`endif
   output logic        busy
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = ptr_w(DEPTH);

   pe_drv_state   r_state;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] r_rptr;
   logic [CW-1:0] r_cptr;
   single_float   r_res_dat;
   logic          r_res_err;
   error          r_res_user;

`ifdef PE_STREAM_DRIVER_TIMEOUT_EN
   localparam int TW = ptr_w(TIMEOUT);
   logic [TW-1:0] r_tmr;
   logic          r_res_timeout;
`else
   logic          w_unused_cfg;
   assign w_unused_cfg = (TIMEOUT > 0);
`endif

   logic        w_ld_fire;
   logic        w_row_fire;
   logic        w_col_fire;
   logic        w_streamed;
   logic        w_take;
   operand_pair w_wdata;
   operand_pair w_row_pair;
   operand_pair w_col_pair;
   logic        w_unused_pe;

   // The PE's forwarded operands are only drained, never used.
   assign w_unused_pe = ^{row_out_dat, col_out_dat, row_out_valid, col_out_valid,
                          w_row_pair.col, w_col_pair.row};

   // Handshake outputs are decoded from the registered state and masked by
   // rst so a reset cycle can never complete a transfer on either side.
   assign ld_ready      = !rst && (r_state == LOAD);
   assign row_in_valid  = !rst && (r_state == STREAM) && (r_rptr < r_cnt);
   assign col_in_valid  = !rst && (r_state == STREAM) && (r_cptr < r_cnt);
   assign row_out_ready = !rst && ((r_state == STREAM) || (r_state == WAIT));
   assign col_out_ready = row_out_ready;
   assign res_valid     = !rst && (r_state == RESULT);
   assign busy          = !rst && (r_state != LOAD);

   assign res_dat  = r_res_dat;
   assign res_err  = r_res_err;
   assign res_user = r_res_user;
`ifdef PE_STREAM_DRIVER_TIMEOUT_EN
   assign res_timeout = r_res_timeout;
`endif

   assign w_ld_fire  = ld_valid && ld_ready;
   assign w_row_fire = row_in_valid && row_in_ready;
   assign w_col_fire = col_in_valid && col_in_ready;
   assign w_streamed = (r_rptr == r_cnt) && (r_cptr == r_cnt);

   // comp_done counts only once every operand has left on both streams;
   // earlier pulses belong to nothing we launched and are ignored.
   assign w_take = comp_done &&
                   ((r_state == WAIT) || ((r_state == STREAM) && w_streamed));

   assign w_wdata.row = ld_row_dat;
   assign w_wdata.col = ld_col_dat;

   pe_operand_buf #(
      .DEPTH (DEPTH)
   ) u_buf (
      .i_clk     (clk),
      .i_we      (w_ld_fire),
      .i_waddr   (r_cnt[AW-1:0]),
      .i_wdata   (w_wdata),
      .i_raddr_a (r_rptr[AW-1:0]),
      .o_rdata_a (w_row_pair),
      .i_raddr_b (r_cptr[AW-1:0]),
      .o_rdata_b (w_col_pair)
   );

   assign row_in_dat = w_row_pair.row;
   assign col_in_dat = w_col_pair.col;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= LOAD;
         r_cnt      <= '0;
         r_rptr     <= '0;
         r_cptr     <= '0;
         r_res_dat  <= '0;
         r_res_err  <= 1'b0;
         r_res_user <= '0;
`ifdef PE_STREAM_DRIVER_TIMEOUT_EN
         r_tmr         <= '0;
         r_res_timeout <= 1'b0;
`endif
      end else begin
         if (w_take) begin
            r_res_dat  <= accum_sum;
            r_res_err  <= error_bit;
            r_res_user <= user;
`ifdef PE_STREAM_DRIVER_TIMEOUT_EN
            r_res_timeout <= 1'b0;
`endif
         end

         case (r_state)
            LOAD: begin
               if (w_ld_fire) begin
                  r_cnt <= r_cnt + 1'b1;
                  // Last beat either by marker or because it fills the buffer.
                  if (ld_last || (r_cnt == CW'(DEPTH - 1))) begin
                     r_state <= STREAM;
                  end
               end
            end

            STREAM: begin
               if (w_row_fire) begin
                  r_rptr <= r_rptr + 1'b1;
               end
               if (w_col_fire) begin
                  r_cptr <= r_cptr + 1'b1;
               end
               if (w_streamed) begin
                  if (comp_done) begin
                     r_state <= RESULT;
                  end else begin
                     r_state <= WAIT;
`ifdef PE_STREAM_DRIVER_TIMEOUT_EN
                     r_tmr   <= '0;
`endif
                  end
               end
            end

            WAIT: begin
               if (comp_done) begin
                  r_state <= RESULT;
               end
`ifdef PE_STREAM_DRIVER_TIMEOUT_EN
               else if (r_tmr == TW'(TIMEOUT)) begin
                  r_state       <= RESULT;
                  r_res_dat     <= '0;
                  r_res_err     <= 1'b1;
                  r_res_user    <= '0;
                  r_res_timeout <= 1'b1;
               end else begin
                  r_tmr <= r_tmr + 1'b1;
               end
`endif
            end

            RESULT: begin
               if (res_ready) begin
                  r_cnt   <= '0;
                  r_rptr  <= '0;
                  r_cptr  <= '0;
                  r_state <= LOAD;
               end
            end

            default: begin
               r_state <= LOAD;
            end
         endcase
      end
   end

endmodule
